// File: rtl/io_bus_resp.sv
// ---------------------------------------------------------------------------
// io_bus_resp
// Small I/O-space register block answering CPU bus cycles. It decodes eight
// byte addresses starting at BASE_ADDR (four 16-bit words):
//   word 0 SCRATCH0 (rw), word 1 SCRATCH1 (rw), word 2 CTRL (rw, drives led),
//   word 3 WRCNT (ro, counts every committed write including writes to itself).
//
// Optional feature: define IO_RESP_WAIT_EN to insert WAIT_CYC wait states
// between the decode hit and the ready strobe. Without it the WAIT state and
// its counter are not built and ready follows the decode hit by one cycle.
//
// Parameters
//   BASE_ADDR  I/O byte address of register 0 (bits [2:0] ignored)
//   WAIT_CYC   wait states, 0..15, only meaningful with IO_RESP_WAIT_EN
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   addr     in   [19:0] CPU address, bits [15:0] decoded
//   wr_data  in   [15:0] CPU write data
//   we       in   active-low write strobe (0 = write, 1 = read)
//   byte_m   in   1 = byte access, 0 = word access
//   m_io     in   1 = I/O space cycle
//   mem_op   in   bus cycle request
//   rd_data  out  [15:0] registered read data, non-zero only while ready=1
//   ready    out  one-cycle completion strobe
//   io_cs    out  combinational decode hit
//   led      out  [1:0] CTRL[1:0]
// ---------------------------------------------------------------------------
module io_bus_resp #(
    parameter logic [15:0] BASE_ADDR = 16'h00B0,
    parameter int unsigned WAIT_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        byte_m,
    input  logic        m_io,
    input  logic        mem_op,
    output logic [15:0] rd_data,
    output logic        ready,
    output logic        io_cs,
    output logic [1:0]  led
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t      state, state_nxt;
    logic [15:0] scratch0, scratch1, ctrl, wrcnt;
    logic [15:0] scratch0_nxt, scratch1_nxt, ctrl_nxt, wrcnt_nxt;
    logic [15:0] rd_nxt;
    logic [15:0] reg_cur;
    logic        enter_ack;

    // Transaction attributes used at commit time.
    logic [2:0]  cur_a;
    logic        cur_we;
    logic        cur_byte;
    logic [15:0] cur_wdata;

    // Address bits above the decoded window and the wait parameter (unused
    // when wait states are not built) are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[19:16], WAIT_CYC[0]};

    assign io_cs = mem_op & m_io & (addr[15:3] == BASE_ADDR[15:3]);
    assign led   = ctrl[1:0];

    // Merge write data into a register for word or byte (low/high) writes.
    // Byte writes always take their data from wr_data[7:0].
    function automatic logic [15:0] merge_write(input logic [15:0] old,
                                                input logic [15:0] d,
                                                input logic        bm,
                                                input logic        hi);
        if (!bm)
            return d;
        else if (hi)
            return {d[7:0], old[7:0]};
        else
            return {old[15:8], d[7:0]};
    endfunction

    // Byte reads return the selected byte right-justified.
    function automatic logic [15:0] read_sel(input logic [15:0] r,
                                             input logic        bm,
                                             input logic        hi);
        if (!bm)
            return r;
        else
            return {8'h00, (hi ? r[15:8] : r[7:0])};
    endfunction

`ifdef IO_RESP_WAIT_EN
    logic [3:0]  cnt, cnt_nxt;
    logic [2:0]  a_lat;
    logic        we_lat;
    logic        byte_lat;
    logic [15:0] wdata_lat;

    // In IDLE the commit (WAIT_CYC=0) happens on the same edge that latches,
    // so the live bus values are used; afterwards the latched copy is used.
    always_comb begin
        if (state == IDLE) begin
            cur_a     = addr[2:0];
            cur_we    = we;
            cur_byte  = byte_m;
            cur_wdata = wr_data;
        end else begin
            cur_a     = a_lat;
            cur_we    = we_lat;
            cur_byte  = byte_lat;
            cur_wdata = wdata_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && io_cs) begin
            a_lat     <= addr[2:0];
            we_lat    <= we;
            byte_lat  <= byte_m;
            wdata_lat <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 4'd0;
        else
            cnt <= cnt_nxt;
    end
`else
    // Without wait states the commit edge is the decode edge itself.
    always_comb begin
        cur_a     = addr[2:0];
        cur_we    = we;
        cur_byte  = byte_m;
        cur_wdata = wr_data;
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
`ifdef IO_RESP_WAIT_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            IDLE: begin
                if (io_cs) begin
`ifdef IO_RESP_WAIT_EN
                    if (WAIT_CYC == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_CYC[3:0];
                    end
`else
                    state_nxt = ACK;
`endif
                end
            end
            WAIT: begin
`ifdef IO_RESP_WAIT_EN
                // Losing the decode mid-wait abandons the access entirely.
                if (!io_cs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nxt = ACK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                end
`else
                state_nxt = IDLE;
`endif
            end
            ACK:     state_nxt = HOLD;
            // Wait for the CPU to end the cycle so one request gives one ack.
            HOLD:    if (!io_cs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_ack = (state_nxt == ACK);

    // Register file commit and read data, evaluated for the edge entering ACK
    always_comb begin
        scratch0_nxt = scratch0;
        scratch1_nxt = scratch1;
        ctrl_nxt     = ctrl;
        wrcnt_nxt    = wrcnt;
        rd_nxt       = 16'h0000;

        case (cur_a[2:1])
            2'd0:    reg_cur = scratch0;
            2'd1:    reg_cur = scratch1;
            2'd2:    reg_cur = ctrl;
            default: reg_cur = wrcnt;
        endcase

        if (enter_ack) begin
            if (!cur_we) begin
                wrcnt_nxt = wrcnt + 16'd1;
                case (cur_a[2:1])
                    2'd0:    scratch0_nxt = merge_write(scratch0, cur_wdata, cur_byte, cur_a[0]);
                    2'd1:    scratch1_nxt = merge_write(scratch1, cur_wdata, cur_byte, cur_a[0]);
                    2'd2:    ctrl_nxt     = merge_write(ctrl, cur_wdata, cur_byte, cur_a[0]);
                    default: ;  // WRCNT is read-only; only the increment applies
                endcase
            end else begin
                rd_nxt = read_sel(reg_cur, cur_byte, cur_a[0]);
            end
        end
    end

    // State and register update; reset overrides any pending commit/ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scratch0 <= 16'h0000;
            scratch1 <= 16'h0000;
            ctrl     <= 16'h0000;
            wrcnt    <= 16'h0000;
            ready    <= 1'b0;
            rd_data  <= 16'h0000;
        end else begin
            state    <= state_nxt;
            scratch0 <= scratch0_nxt;
            scratch1 <= scratch1_nxt;
            ctrl     <= ctrl_nxt;
            wrcnt    <= wrcnt_nxt;
            ready    <= enter_ack;
            rd_data  <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_io_bus_resp.sv
// ---------------------------------------------------------------------------
// tb_io_bus_resp
// Directed bench for io_bus_resp. Each access pushes its expected read data
// (0 for writes) into a queue; an independent monitor pops and compares on
// every ready pulse. Register contents are observed through read accesses.
// Works with or without IO_RESP_WAIT_EN defined.
// ---------------------------------------------------------------------------
module tb_io_bus_resp;

    localparam logic [15:0] BASE = 16'h00B0;
    localparam int unsigned WC   = 2;
`ifdef IO_RESP_WAIT_EN
    localparam int EXP_LAT = 1 + WC;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [19:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        byte_m;
    logic        m_io;
    logic        mem_op;
    logic [15:0] rd_data;
    logic        ready;
    logic        io_cs;
    logic [1:0]  led;

    io_bus_resp #(.BASE_ADDR(BASE), .WAIT_CYC(WC)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr_data (wr_data),
        .we      (we),
        .byte_m  (byte_m),
        .m_io    (m_io),
        .mem_op  (mem_op),
        .rd_data (rd_data),
        .ready   (ready),
        .io_cs   (io_cs),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total  = 0;
    int          bad    = 0;
    int          pulses = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: rd_data=%h, nothing expected", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_data: got %h want %h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic idle_bus();
        mem_op  = 1'b0;
        m_io    = 1'b0;
        we      = 1'b1;
        byte_m  = 1'b0;
        addr    = 20'h0;
        wr_data = 16'h0;
    endtask

    // One complete access, starting and ending at a negedge.
    task automatic access(input logic [19:0] a, input logic w, input logic b,
                          input logic [15:0] d, input logic [15:0] exp,
                          input int extra_hold, input string name);
        int cyc;
        cyc = 0;
        exp_q.push_back(exp);
        addr = a; we = w; byte_m = b; wr_data = d; m_io = 1'b1; mem_op = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
        end while (ready !== 1'b1 && cyc < 40);
        check({name, "_latency"}, cyc, EXP_LAT);
        if (ready !== 1'b1) void'(exp_q.pop_back());
        repeat (extra_hold) @(negedge clk);
        idle_bus();
        repeat (2) @(negedge clk);
    endtask

    task automatic rd(input logic [19:0] a, input logic b, input logic [15:0] exp, input string name);
        access(a, 1'b1, b, 16'h0, exp, 0, name);
    endtask

    task automatic wr(input logic [19:0] a, input logic b, input logic [15:0] d, input string name);
        access(a, 1'b0, b, d, 16'h0000, 0, name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1'b0);
        check("reset_rd_data", rd_data, 16'h0);
        check("reset_led", led, 2'b00);
        check("reset_io_cs", io_cs, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        rd(20'h000B6, 1'b0, 16'h0000, "wrcnt_init");

        // Word write then read back
        wr(20'h000B0, 1'b0, 16'h1234, "wr_scratch0");
        rd(20'h000B0, 1'b0, 16'h1234, "rd_scratch0");
        rd(20'h000B6, 1'b0, 16'h0001, "wrcnt_1");

        // Byte writes and reads
        wr(20'h000B2, 1'b0, 16'h1234, "wr_scratch1");
        wr(20'h000B3, 1'b1, 16'h00AB, "wr_byte_hi");
        rd(20'h000B2, 1'b0, 16'hAB34, "rd_scratch1");
        rd(20'h000B3, 1'b1, 16'h00AB, "rd_byte_hi");
        rd(20'h000B2, 1'b1, 16'h0034, "rd_byte_lo");
        wr(20'h000B0, 1'b1, 16'hFF55, "wr_byte_lo");
        rd(20'h000B1, 1'b0, 16'h1255, "rd_word_odd");

        // CTRL drives led
        wr(20'h000B4, 1'b0, 16'h0003, "wr_ctrl");
        check("led_ctrl", led, 2'b11);
        rd(20'h000B4, 1'b0, 16'h0003, "rd_ctrl");

        // Write to WRCNT only increments it
        wr(20'h000B6, 1'b0, 16'hFFFF, "wr_wrcnt");
        rd(20'h000B6, 1'b0, 16'h0006, "wrcnt_6");

        // Long-held request: one ack, one increment
        p0 = pulses;
        access(20'h000B0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 9, "hold");
        check("hold_pulses", pulses - p0, 1);
        rd(20'h000B6, 1'b0, 16'h0007, "wrcnt_7");
        rd(20'h000B0, 1'b0, 16'hBEEF, "rd_hold");

        // Out-of-range and non-I/O cycles
        p0 = pulses;
        addr = 20'h000C0; we = 1'b0; wr_data = 16'h5A5A; m_io = 1'b1; mem_op = 1'b1;
        #1 check("io_cs_c0", io_cs, 1'b0);
        addr = 20'h000B8;
        #1 check("io_cs_b8", io_cs, 1'b0);
        addr = 20'h000B0; m_io = 1'b0;
        #1 check("io_cs_mem", io_cs, 1'b0);
        m_io = 1'b1;
        #1 check("io_cs_hit", io_cs, 1'b1);
        addr = 20'h000C0;
        repeat (8) @(negedge clk);
        check("oor_pulses", pulses - p0, 0);
        idle_bus();
        @(negedge clk);
        rd(20'h000B6, 1'b0, 16'h0007, "wrcnt_oor");
        rd(20'h100B0, 1'b0, 16'hBEEF, "rd_upper_addr");

        // WRCNT wrap: preload FFFF, then one write
        force dut.wrcnt = 16'hFFFF;
        @(negedge clk);
        release dut.wrcnt;
        @(negedge clk);
        wr(20'h000B2, 1'b0, 16'h0001, "wr_wrap");
        rd(20'h000B6, 1'b0, 16'h0000, "wrcnt_wrap");
        rd(20'h000B2, 1'b0, 16'h0001, "rd_wrap");

`ifdef IO_RESP_WAIT_EN
        // Abort by dropping the request mid-wait
        p0 = pulses;
        addr = 20'h000B0; we = 1'b0; byte_m = 1'b0; wr_data = 16'h1111; m_io = 1'b1; mem_op = 1'b1;
        @(negedge clk);
        idle_bus();
        repeat (5) @(negedge clk);
        check("abort_pulses", pulses - p0, 0);
        rd(20'h000B0, 1'b0, 16'hBEEF, "rd_abort");
        rd(20'h000B6, 1'b0, 16'h0000, "wrcnt_abort");

        // Reset in the middle of the wait
        addr = 20'h000B0; we = 1'b0; byte_m = 1'b0; wr_data = 16'h2222; m_io = 1'b1; mem_op = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstwait_ready", ready, 1'b0);
        check("rstwait_rd_data", rd_data, 16'h0);
        check("rstwait_led", led, 2'b00);
        rst = 1'b0;
        idle_bus();
        repeat (2) @(negedge clk);
        rd(20'h000B0, 1'b0, 16'h0000, "rd_rstwait");
        wr(20'h000B4, 1'b0, 16'h0002, "wr_ctrl2");
        check("led_ctrl2", led, 2'b10);
`endif

        // Reset on the edge that would have entered ACK
        p0 = pulses;
        addr = 20'h000B2; we = 1'b0; byte_m = 1'b0; wr_data = 16'h5555; m_io = 1'b1; mem_op = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rstack_ready", ready, 1'b0);
        check("rstack_rd_data", rd_data, 16'h0);
        check("rstack_led", led, 2'b00);
        rst = 1'b0;
        idle_bus();
        repeat (2) @(negedge clk);
        check("rstack_pulses", pulses - p0, 0);
        rd(20'h000B2, 1'b0, 16'h0000, "rd_rstack");
        rd(20'h000B6, 1'b0, 16'h0000, "wrcnt_rstack");

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_bus_resp.md
IO_BUS_RESP -- requirements
Module: io_bus_resp

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h00B0: I/O byte address of register 0; the block decodes BASE_ADDR..BASE_ADDR+7.
REQ-002 SHALL have parameter WAIT_CYC, default 2: extra wait cycles before ready, used only when IO_RESP_WAIT_EN is defined; legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock for the block.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port addr  input  20  CPU address; only bits [15:0] are decoded.
REQ-006 SHALL have port wr_data  input  16  CPU write data.
REQ-007 SHALL have port we  input  1  active-low write strobe: 0 = write, 1 = read.
REQ-008 SHALL have port byte_m  input  1  1 = byte access, 0 = word access.
REQ-009 SHALL have port m_io  input  1  1 = I/O space cycle.
REQ-010 SHALL have port mem_op  input  1  CPU bus cycle request.
REQ-011 SHALL have port rd_data  output  16  read data.
REQ-012 SHALL have port ready  output  1  one-cycle completion strobe.
REQ-013 SHALL have port io_cs  output  1  combinational decode hit, used by the top level for the rd_data/ready mux.
REQ-014 SHALL have port led  output  2  mirrors REG2[1:0].

Function
REQ-015 io_cs SHALL equal mem_op & m_io & (addr[15:3] == BASE_ADDR[15:3]).
REQ-016 Register map (word index addr[2:1]):
- 0: SCRATCH0, read/write.
- 1: SCRATCH1, read/write.
- 2: CTRL, read/write; drives led.
- 3: WRCNT, read-only; counts committed writes to any index, 16-bit, wraps FFFF to 0000.
REQ-017 FSM states SHALL be IDLE, WAIT, ACK and HOLD.
- IDLE: on io_cs, latch addr[2:0], we, byte_m and wr_data, then go to WAIT. Without the macro, or with WAIT_CYC=0, go directly to ACK.
- WAIT: decrement the counter; go to ACK when the count reaches 0.
- ACK: ready=1 for exactly one cycle; next state is HOLD.
- HOLD: stay until io_cs=0, then return to IDLE. Re-trigger without io_cs dropping SHALL NOT occur.
REQ-018 Latency: io_cs is first sampled high at edge k; ready SHALL be high during cycle k+1 (no macro) or during cycle k+1+WAIT_CYC (with macro).
REQ-019 Writes SHALL commit at the clock edge that enters ACK, using the latched values.
- Word write: writes all 16 bits.
- Byte write: addr[0]=0 writes bits [7:0] from wr_data[7:0]; addr[0]=1 writes bits [15:8] from wr_data[7:0].
REQ-020 Write to WRCNT SHALL be ignored, but it still SHALL be acked and SHALL increment WRCNT.
REQ-021 The WRCNT increment SHALL happen at the same edge as the commit, once per transaction.
REQ-022 rd_data SHALL be registered, valid only while ready=1, and 16'h0000 otherwise.
- Word read returns the full register; addr[0] is ignored.
- Byte read returns the selected byte in [7:0], with [15:8]=0.
- Write cycles return 0.
REQ-023 io_cs dropping during WAIT SHALL abort the transaction: return to IDLE, no commit, no ready.
REQ-024 Accesses outside the decoded range SHALL cause no state change and keep ready=0.

Reset
REQ-025 While rst=1 at an edge:
- SCRATCH0, SCRATCH1, CTRL and WRCNT SHALL be set to 0.
- The FSM SHALL go to IDLE and the wait counter to 0.
- ready, rd_data and led SHALL be 0.
REQ-026 Reset asserted in WAIT or ACK SHALL take priority: no commit and no ready in that cycle.

Configuration
REQ-027 Macro IO_RESP_WAIT_EN SHALL control wait-state insertion.
- Defined: WAIT_CYC wait states are inserted.
- Undefined: the WAIT state and counter are not built; IDLE goes to ACK with fixed 1-cycle latency, and WAIT_CYC is ignored.

Verification
REQ-028 Word write: mem_op=1, m_io=1, addr=0x000B0, we=0, byte_m=0, wr_data=16'h1234 -> ready after 1 cycle (no macro) or 3 cycles (macro, WAIT_CYC=2); SCRATCH0=16'h1234; WRCNT=1.
REQ-029 Byte write: addr=0x000B3, byte_m=1, wr_data=16'h00AB, with SCRATCH1=16'h1234 -> SCRATCH1=16'hAB34. A byte read of 0x000B3 -> rd_data=16'h00AB while ready=1.
REQ-030 CTRL: word write 0x000B4 with 16'h0003 -> led=2'b11 from the ACK edge. Write 0x000B6 with 16'hFFFF -> WRCNT unchanged except for its +1 increment.
REQ-031 Hold request: mem_op held high for 10 cycles on one access -> exactly one ready pulse and one WRCNT increment. addr=0x000C0 -> io_cs=0 and ready never asserts.
REQ-032 Wrap and abort: preload WRCNT=16'hFFFF with one write -> WRCNT=0. With the macro, drop mem_op in WAIT -> no commit and no ready. Assert rst in WAIT -> all outputs 0, FSM in IDLE.
